// File: rtl/herald_host_master.sv
// Host-side bus master for the Herald byte-strobe accelerator: serialises a word request into
// write strobes, polls BUSY, collects result bytes. Optional poll watchdog: HERALD_HOST_TIMEOUT_EN.
module herald_host_master #(
   parameter int unsigned STROBE_CYCLES  = 2,
   parameter int unsigned BUSY_SETTLE    = 3,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_cmd,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic        rsp_err,
   output logic [7:0]  bus_data,
   output logic        bus_wr,
   output logic        bus_rd,
   input  logic [7:0]  bus_in
);

`ifdef HERALD_HOST_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   localparam logic [15:0] STROBE_LAST  = 16'(STROBE_CYCLES - 1);
   localparam logic [15:0] SETTLE_LAST  = 16'(BUSY_SETTLE - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_HI, S_WR_LO, S_SETTLE, S_POLL, S_RD_HI, S_RD_LO, S_RESP
   } state_t;

   state_t      state, state_nx;
   logic [15:0] cnt;
   logic [3:0]  idx;
   logic [7:0]  cmd_q;
   logic [31:0] a_q, b_q;
   logic        cap_pend;
   logic [3:0]  n_wr, n_rd;
   logic [3:0]  req_n_wr, req_n_rd;
   logic        req_supported;
   logic        strobe_done, last_wr, last_rd, timeout_hit, cnt_clr;

   // {write count, read count}; zero writes marks an unsupported code
   function automatic logic [7:0] cmd_shape(input logic [7:0] c);
      case (c)
         8'h10:                      return {4'd5, 4'd8};
         8'h11, 8'h12, 8'h20, 8'h21: return {4'd9, 4'd4};
         8'h22:                      return {4'd1, 4'd0};
         default:                    return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] wr_byte(input logic [3:0] i);
      case (i)
         4'd0:    return cmd_q;
         4'd1:    return a_q[7:0];
         4'd2:    return a_q[15:8];
         4'd3:    return a_q[23:16];
         4'd4:    return a_q[31:24];
         4'd5:    return b_q[7:0];
         4'd6:    return b_q[15:8];
         4'd7:    return b_q[23:16];
         4'd8:    return b_q[31:24];
         default: return 8'h00;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx              = state;
      {n_wr, n_rd}          = cmd_shape(cmd_q);
      {req_n_wr, req_n_rd}  = cmd_shape(req_cmd);
      req_supported         = (req_n_wr != 4'd0);
      strobe_done           = (cnt == STROBE_LAST);
      last_wr               = (idx == n_wr - 4'd1);
      last_rd               = (idx == n_rd - 4'd1);
      timeout_hit           = TIMEOUT_EN && (state == S_POLL) && bus_in[7] && (cnt == TIMEOUT_LAST);
      req_ready             = (state == S_IDLE);
      rsp_valid             = (state == S_RESP);
      bus_wr                = (state == S_WR_HI);
      bus_rd                = (state == S_RD_HI);

      case (state)
         S_IDLE:   if (req_valid) state_nx = req_supported ? S_WR_HI : S_RESP;
         S_WR_HI:  if (strobe_done) state_nx = S_WR_LO;
         S_WR_LO:  if (strobe_done) begin
                      if (!last_wr)              state_nx = S_WR_HI;
                      else if (BUSY_SETTLE == 0) state_nx = S_POLL;
                      else                       state_nx = S_SETTLE;
                   end
         S_SETTLE: if (cnt == SETTLE_LAST) state_nx = S_POLL;
         S_POLL:   begin
                      if (!bus_in[7])       state_nx = (n_rd == 4'd0) ? S_RESP : S_RD_HI;
                      else if (timeout_hit) state_nx = S_RESP;
                   end
         S_RD_HI:  if (strobe_done) state_nx = S_RD_LO;
         S_RD_LO:  if (strobe_done) state_nx = last_rd ? S_RESP : S_RD_HI;
         S_RESP:   if (rsp_ready) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase

      // phase timer restarts on every state change; the poll count only runs with the watchdog
      cnt_clr = (state_nx != state) || (state == S_IDLE) || (state == S_RESP) ||
                ((state == S_POLL) && !TIMEOUT_EN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         idx      <= '0;
         cmd_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cap_pend <= 1'b0;
         bus_data <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         // device drives the byte for one cycle, two edges after the read strobe rises
         cap_pend <= (state == S_RD_HI) && (cnt == '0);
         if (cap_pend) rsp_data[{idx[2:0], 3'b000} +: 8] <= bus_in;

         if (cnt_clr) cnt <= '0;
         else         cnt <= cnt + 16'd1;

         case (state)
            S_IDLE:  if (req_valid) begin
                        cmd_q    <= req_cmd;
                        a_q      <= req_a;
                        b_q      <= req_b;
                        idx      <= '0;
                        rsp_data <= '0;
                        rsp_err  <= !req_supported;
                        bus_data <= req_supported ? req_cmd : 8'h00;
                     end
            // next byte is staged as the strobe falls, giving it the whole low phase to settle
            S_WR_HI: if (strobe_done) bus_data <= last_wr ? 8'h00 : wr_byte(idx + 4'd1);
            S_WR_LO: if (strobe_done) idx <= last_wr ? 4'd0 : idx + 4'd1;
            S_POLL:  if (timeout_hit) rsp_err <= 1'b1;
            S_RD_LO: if (strobe_done) idx <= idx + 4'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_herald_host_master.sv
// Self-checking bench for herald_host_master: reactive device model on the bus plus a
// command-table reference model for strobe bytes, read counts and response values.
module tb_herald_host_master;
   localparam int SC = 2;

   logic        clk, rst_n;
   logic        req_valid, req_ready;
   logic [7:0]  req_cmd;
   logic [31:0] req_a, req_b;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [63:0] rsp_data;
   logic [7:0]  bus_data, bus_in;
   logic        bus_wr, bus_rd;

   herald_host_master #(.STROBE_CYCLES(SC), .BUSY_SETTLE(3), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .bus_data(bus_data), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_in(bus_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // device model state
   logic [7:0]  wr_log[$];
   logic [7:0]  exp_wr[$];
   int          rd_cnt = 0;
   int          viol = 0;
   int          busy_len = 0;
   bit          busy_stuck = 0;
   logic [63:0] dev_result = '0;
   bit          prev_wr = 0, prev_rd = 0, present = 0, rise, fall, first_wr = 0;
   int          busy_cnt = 0, rd_idx = 0, low_run = 100, high_run = 0;
   logic [7:0]  wr_hold = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_wr = 0; prev_rd = 0; present = 0; busy_cnt = 0; rd_idx = 0;
         low_run = 100; high_run = 0; bus_in = 8'h00;
      end else begin
         rise = (bus_wr && !prev_wr) || (bus_rd && !prev_rd);
         fall = (!bus_wr && prev_wr) || (!bus_rd && prev_rd);
         if (bus_wr && bus_rd) viol++;
         if (fall && high_run != SC) viol++;
         if (rise) begin
            if (low_run < SC) viol++;
            high_run = 0;
         end
         if (bus_wr || bus_rd) begin high_run++; low_run = 0; end
         else low_run++;

         if (bus_wr && !prev_wr) begin
            wr_log.push_back(bus_data);
            wr_hold  = bus_data;
            rd_idx   = 0;
            busy_cnt = busy_len;
         end else begin
            if (bus_wr && bus_data !== wr_hold) viol++;
            if (busy_cnt > 0) busy_cnt--;
         end

         if (present) begin
            bus_in = dev_result[8*(rd_idx%8) +: 8];
            rd_idx++;
         end else begin
            bus_in = {busy_stuck || (busy_cnt > 0), 7'($urandom)};
         end
         present = bus_rd && !prev_rd;
         if (present) rd_cnt++;
         prev_wr = bus_wr;
         prev_rd = bus_rd;
      end
   end

   // Reference model: command table, operands emitted little-endian after the command byte.
   function automatic void ref_model(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b,
                                     input logic [63:0] res, output int nw, output int nr,
                                     output bit err, output logic [63:0] data);
      logic [71:0] ops;
      case (c)
         8'h10:                      begin nw = 5; nr = 8; end
         8'h11, 8'h12, 8'h20, 8'h21: begin nw = 9; nr = 4; end
         8'h22:                      begin nw = 1; nr = 0; end
         default:                    begin nw = 0; nr = 0; end
      endcase
      err = (nw == 0);
      ops = {b, a, c};
      exp_wr.delete();
      for (int i = 0; i < nw; i++) exp_wr.push_back(ops[8*i +: 8]);
      if (nr == 8)      data = res;
      else if (nr == 4) data = {32'h0, res[31:0]};
      else              data = 64'h0;
   endfunction

   task automatic start_txn(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b);
      int k = 0;
      @(negedge clk); #1;
      while (!req_ready && k < 50) begin @(negedge clk); #1; k++; end
      total++;
      if (!req_ready) begin
         bad++;
         $display("FAIL req_ready_wait: req_ready=%0b required 1", req_ready);
      end
      wr_log.delete(); rd_cnt = 0; viol = 0;
      req_cmd = c; req_a = a; req_b = b; req_valid = 1'b1;
      @(posedge clk);
   endtask

   task automatic wait_rsp(input int limit, output bit got, output int lat);
      got = 0; lat = -1;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (k == 0) begin req_valid = 1'b0; first_wr = bus_wr; end
         if (rsp_valid) begin got = 1; lat = k; break; end
      end
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++; if (bus_wr !== 1'b0)    begin bad++; $display("FAIL reset_bus_wr: got %b want 0", bus_wr); end
      total++; if (bus_rd !== 1'b0)    begin bad++; $display("FAIL reset_bus_rd: got %b want 0", bus_rd); end
      total++; if (bus_data !== 8'h00) begin bad++; $display("FAIL reset_bus_data: got %h want 00", bus_data); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      total++; if (rsp_err !== 1'b0)   begin bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
      total++; if (rsp_data !== 64'h0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      #2 rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [7:0]  cmds[3] = '{8'h20, 8'h10, 8'h22};
      logic [31:0] as[3]   = '{32'h00000003, 32'h12345678, 32'hDEADBEEF};
      logic [31:0] bs[3]   = '{32'h00000005, 32'hCAFEF00D, 32'h0BADC0DE};
      logic [63:0] res[3]  = '{64'h000000000000000F, 64'h0123456789ABCDEF, 64'h5555AAAA5555AAAA};
      int nw, nr, lat; bit e_err, got; logic [63:0] e_data;
      for (int t = 0; t < 3; t++) begin
         busy_len = 2 * t;
         dev_result = res[t];
         ref_model(cmds[t], as[t], bs[t], res[t], nw, nr, e_err, e_data);
         start_txn(cmds[t], as[t], bs[t]);
         wait_rsp(300, got, lat);
         total++; if (first_wr !== 1'b1) begin bad++; $display("FAIL dir%0d_first_wr: bus_wr=%b want 1", t, first_wr); end
         total++;
         if (!got) begin bad++; $display("FAIL dir%0d_rsp_timeout: rsp_valid=0 want 1", t); end
         else begin
            total++; if (rsp_err !== e_err)   begin bad++; $display("FAIL dir%0d_err: got %b want %b", t, rsp_err, e_err); end
            total++; if (rsp_data !== e_data) begin bad++; $display("FAIL dir%0d_data: got %h want %h", t, rsp_data, e_data); end
            finish_rsp();
         end
         total++; if (wr_log.size() != nw) begin bad++; $display("FAIL dir%0d_wr_count: got %0d want %0d", t, wr_log.size(), nw); end
         for (int i = 0; i < nw && i < wr_log.size(); i++) begin
            total++; if (wr_log[i] !== exp_wr[i]) begin bad++; $display("FAIL dir%0d_wr_byte%0d: got %h want %h", t, i, wr_log[i], exp_wr[i]); end
         end
         total++; if (rd_cnt != nr) begin bad++; $display("FAIL dir%0d_rd_count: got %0d want %0d", t, rd_cnt, nr); end
         total++; if (viol != 0)    begin bad++; $display("FAIL dir%0d_protocol: violations %0d want 0", t, viol); end
      end
   endtask

   task automatic test_unsupported();
      bit got; int lat;
      start_txn(8'h55, 32'h11111111, 32'h22222222);
      wait_rsp(10, got, lat);
      total++;
      if (!got || lat > 1) begin bad++; $display("FAIL unsup_latency: got=%0b lat=%0d want rsp within 2 cycles", got, lat); end
      else begin
         total++; if (rsp_err !== 1'b1)   begin bad++; $display("FAIL unsup_err: got %b want 1", rsp_err); end
         total++; if (rsp_data !== 64'h0) begin bad++; $display("FAIL unsup_data: got %h want 0", rsp_data); end
         finish_rsp();
      end
      if (rsp_valid) finish_rsp();
      total++; if (wr_log.size() != 0) begin bad++; $display("FAIL unsup_wr_count: got %0d want 0", wr_log.size()); end
      total++; if (rd_cnt != 0)        begin bad++; $display("FAIL unsup_rd_count: got %0d want 0", rd_cnt); end
   endtask

   task automatic test_random();
      logic [7:0] c; logic [31:0] a, b; logic [63:0] r, e_data;
      int nw, nr, lat, sel; bit e_err, got;
      for (int t = 0; t < 30; t++) begin
         sel = $urandom_range(0, 7);
         case (sel)
            0: c = 8'h10; 1: c = 8'h11; 2: c = 8'h12; 3: c = 8'h20;
            4: c = 8'h21; 5: c = 8'h22; default: c = 8'($urandom);
         endcase
         a = $urandom; b = $urandom; r = {$urandom, $urandom};
         busy_len = $urandom_range(0, 12);
         dev_result = r;
         ref_model(c, a, b, r, nw, nr, e_err, e_data);
         start_txn(c, a, b);
         wait_rsp(300, got, lat);
         total++;
         if (!got) begin bad++; $display("FAIL rnd%0d_rsp_timeout: cmd=%h rsp_valid=0 want 1", t, c); end
         else begin
            total++; if (rsp_err !== e_err)   begin bad++; $display("FAIL rnd%0d_err: cmd=%h got %b want %b", t, c, rsp_err, e_err); end
            total++; if (rsp_data !== e_data) begin bad++; $display("FAIL rnd%0d_data: cmd=%h got %h want %h", t, c, rsp_data, e_data); end
            finish_rsp();
         end
         total++; if (wr_log.size() != nw) begin bad++; $display("FAIL rnd%0d_wr_count: got %0d want %0d", t, wr_log.size(), nw); end
         for (int i = 0; i < nw && i < wr_log.size(); i++) begin
            total++; if (wr_log[i] !== exp_wr[i]) begin bad++; $display("FAIL rnd%0d_wr_byte%0d: got %h want %h", t, i, wr_log[i], exp_wr[i]); end
         end
         total++; if (rd_cnt != nr) begin bad++; $display("FAIL rnd%0d_rd_count: got %0d want %0d", t, rd_cnt, nr); end
         total++; if (viol != 0)    begin bad++; $display("FAIL rnd%0d_protocol: violations %0d want 0", t, viol); end
      end
   endtask

   task automatic test_rsp_hold();
      logic [31:0] a, b; logic [63:0] e_data; int nw, nr, lat; bit e_err, got;
      a = $urandom; b = $urandom;
      dev_result = {$urandom, $urandom};
      busy_len = 1;
      ref_model(8'h21, a, b, dev_result, nw, nr, e_err, e_data);
      start_txn(8'h21, a, b);
      wait_rsp(300, got, lat);
      total++;
      if (!got) begin bad++; $display("FAIL hold_rsp_timeout: rsp_valid=0 want 1"); end
      else begin
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b1)  begin bad++; $display("FAIL hold_valid%0d: got %b want 1", i, rsp_valid); end
            total++; if (rsp_data !== e_data) begin bad++; $display("FAIL hold_data%0d: got %h want %h", i, rsp_data, e_data); end
            total++; if (rsp_err !== 1'b0)    begin bad++; $display("FAIL hold_err%0d: got %b want 0", i, rsp_err); end
            total++; if (req_ready !== 1'b0)  begin bad++; $display("FAIL hold_req_ready%0d: got %b want 0", i, req_ready); end
         end
         finish_rsp();
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid: got %b want 0", rsp_valid); end
         total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready: got %b want 1", req_ready); end
      end
   endtask

   task automatic test_mid_reset();
      logic [63:0] e_data; int nw, nr, lat; bit e_err, got, seen;
      busy_len = 0;
      start_txn(8'h20, $urandom, $urandom);
      seen = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (k == 0) req_valid = 1'b0;
         #1;
         if (wr_log.size() >= 3) begin seen = 1; break; end
      end
      total++; if (!seen) begin bad++; $display("FAIL midrst_third_write: writes=%0d want 3", wr_log.size()); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      total++; if (bus_wr !== 1'b0)    begin bad++; $display("FAIL midrst_bus_wr: got %b want 0", bus_wr); end
      total++; if (bus_rd !== 1'b0)    begin bad++; $display("FAIL midrst_bus_rd: got %b want 0", bus_rd); end
      total++; if (bus_data !== 8'h00) begin bad++; $display("FAIL midrst_bus_data: got %h want 00", bus_data); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_rsp_valid: got %b want 0", rsp_valid); end
      @(negedge clk); #2 rst_n = 1'b1;
      repeat (12) @(negedge clk);
      total++; if (wr_log.size() != 3 || rd_cnt != 0) begin
         bad++; $display("FAIL midrst_no_strobes: writes=%0d reads=%0d want 3/0", wr_log.size(), rd_cnt);
      end
      dev_result = {$urandom, 32'd14};
      ref_model(8'h20, 32'd2, 32'd7, dev_result, nw, nr, e_err, e_data);
      start_txn(8'h20, 32'd2, 32'd7);
      wait_rsp(300, got, lat);
      total++;
      if (!got) begin bad++; $display("FAIL midrst_mul_timeout: rsp_valid=0 want 1"); end
      else begin
         total++; if (rsp_data !== 64'd14) begin bad++; $display("FAIL midrst_mul_data: got %h want %h", rsp_data, 64'd14); end
         total++; if (rsp_err !== 1'b0)    begin bad++; $display("FAIL midrst_mul_err: got %b want 0", rsp_err); end
         finish_rsp();
      end
      total++; if (wr_log.size() != nw) begin bad++; $display("FAIL midrst_mul_wr_count: got %0d want %0d", wr_log.size(), nw); end
   endtask

   task automatic test_busy_stuck();
      bit got; int lat;
      busy_len = 0;
      busy_stuck = 1;
      start_txn(8'h20, $urandom, $urandom);
`ifdef HERALD_HOST_TIMEOUT_EN
      wait_rsp(300, got, lat);
      total++;
      if (!got) begin bad++; $display("FAIL stuck_rsp_timeout: rsp_valid=0 want 1"); end
      else begin
         total++; if (rsp_err !== 1'b1)   begin bad++; $display("FAIL stuck_err: got %b want 1", rsp_err); end
         total++; if (rsp_data !== 64'h0) begin bad++; $display("FAIL stuck_data: got %h want 0", rsp_data); end
         // 9 strobes of 2+2 cycles, 3 settle, 64 poll cycles
         total++; if (lat < 100 || lat > 106) begin bad++; $display("FAIL stuck_latency: got %0d want about 103", lat); end
         finish_rsp();
      end
      total++; if (rd_cnt != 0) begin bad++; $display("FAIL stuck_rd_count: got %0d want 0", rd_cnt); end
      busy_stuck = 0;
`else
      wait_rsp(1000, got, lat);
      total++; if (got) begin bad++; $display("FAIL stuck_no_rsp: rsp_valid seen at %0d want none", lat); end
      total++; if (rd_cnt != 0) begin bad++; $display("FAIL stuck_rd_count: got %0d want 0", rd_cnt); end
      busy_stuck = 0;
      do_reset();
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stuck_recover: req_ready=%b want 1", req_ready); end
`endif
      total++; if (wr_log.size() != 9) begin bad++; $display("FAIL stuck_wr_count: got %0d want 9", wr_log.size()); end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_directed();
      test_unsupported();
      test_random();
      test_rsp_hold();
      test_mid_reset();
      test_busy_stuck();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/herald_host_master.md
# herald_host_master

Host-side bus master for the Herald byte-strobe accelerator interface. It accepts one word-level request (command plus up to two 32-bit operands), serialises it into write strobes, polls BUSY and collects result bytes with read strobes. It returns a 64-bit response through a valid/ready handshake. It sits in the test harness / companion FPGA driving the accelerator's `ui_in`, `uio_in[1:0]` and `uo_out` pins.

## Interface
- `STROBE_CYCLES`, default 2: cycles each strobe is held high and also held low afterwards; must be ≥1.
- `BUSY_SETTLE`, default 3: cycles to wait after the last write strobe falls, before BUSY polling begins.
- `TIMEOUT_CYCLES`, default 4096: BUSY poll limit; only used when the watchdog is compiled in.
- `clk`, input, 1 bit: the single clock. All logic is clocked on its rising edge.
- `rst_n`, input, 1 bit: synchronous, active-low reset.
- `req_valid`, input, 1 bit: request present.
- `req_ready`, output, 1 bit: high only in IDLE.
- `req_cmd`, input, 8 bits: command code.
- `req_a`, input, 32 bits: operand A.
- `req_b`, input, 32 bits: operand B.
- `rsp_valid`, output, 1 bit: response present; held until accepted.
- `rsp_ready`, input, 1 bit: response accepted.
- `rsp_data`, output, 64 bits: result. Bytes are assembled LSB first; 4-byte results are zero-extended.
- `rsp_err`, output, 1 bit: qualifies `rsp_valid`. Set for an unsupported command or a timeout.
- `bus_data`, output, 8 bits: drives the device's `ui_in`.
- `bus_wr`, output, 1 bit: drives the device's `uio_in[0]`.
- `bus_rd`, output, 1 bit: drives the device's `uio_in[1]`.
- `bus_in`, input, 8 bits: the device's `uo_out`; bit 7 is BUSY.

## Operation
- Command table. Each entry gives write bytes, then read bytes:
  - 0x10 SINCOS: cmd + A (5 writes), 8 reads.
  - 0x11 ATAN2, 0x12 SQRT, 0x20 MUL, 0x21 MAC: cmd + A + B (9 writes), 4 reads.
  - 0x22 CLEAR: cmd only (1 write), 0 reads.
  - Any other code: no bus activity. Go directly to RESP with `rsp_err`=1 and `rsp_data`=0.
- Write order: cmd, then A[7:0]..A[31:24], then B[7:0]..B[31:24].
- States:
  - IDLE: on `req_valid`, latch cmd/A/B and clear the byte index.
  - WR_HI: `bus_data` holds the current byte and `bus_wr`=1 for STROBE_CYCLES.
  - WR_LO: `bus_wr`=0 for STROBE_CYCLES. Then go to the next write byte, or to SETTLE after the last one.
  - SETTLE: BUSY_SETTLE cycles.
  - POLL: wait for `bus_in[7]`==0.
  - RD_HI: `bus_rd`=1 for STROBE_CYCLES.
  - RD_LO: `bus_rd`=0 for STROBE_CYCLES. Then go to the next read, or to RESP.
  - RESP: hold outputs until `rsp_ready`, then go to IDLE.
  - POLL with 0 reads (CLEAR) goes straight to RESP, with `rsp_data`=0 and `rsp_err`=0.
- `bus_data` changes only while `bus_wr`=0. It must be stable on the cycle `bus_wr` rises and throughout the high phase.
- The read byte is captured from `bus_in` on exactly the 2nd rising edge after the edge that raised `bus_rd`. The device presents each byte for one cycle only.
- `rsp_data`, `rsp_err` and `rsp_valid` are stable while `rsp_valid`=1.
- Reset: `bus_wr`=0, `bus_rd`=0, `bus_data`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0, state IDLE, all counters 0.
  - Reset mid-transaction aborts at once, with no further strobes.
  - `rst_n` is shared with the device, so both ends restart together.

## Timing
- `req_ready`=1 only in IDLE. The request is accepted on the cycle where `req_valid` && `req_ready`.
- The first WR_HI cycle follows acceptance by one cycle.
- `bus_wr` and `bus_rd` are never high at the same time.
- Between consecutive strobes there are always ≥STROBE_CYCLES low cycles, so the device's edge detector sees every pulse.
- The RESP → IDLE transition happens on the `rsp_ready` edge. A new request can therefore be accepted no earlier than one cycle after the response handshake.
- With STROBE_CYCLES=1, BUSY_SETTLE=3 and an immediately-free device, CLEAR takes: 1 + 1 (write) + 3 (settle) + 1 (poll) cycles, then RESP.

## Configuration
- `HERALD_HOST_TIMEOUT_EN` defined:
  - A 16-bit counter runs in POLL.
  - Reaching TIMEOUT_CYCLES with BUSY still 1 → RESP with `rsp_err`=1 and `rsp_data`=0. No read strobes are issued.
- `HERALD_HOST_TIMEOUT_EN` undefined: POLL waits indefinitely. `rsp_err` is set only for unsupported commands.

## Test plan
- MUL: A=0x00000003, B=0x00000005, with the device model returning 0x0000000F. Required: 9 write strobes carrying 20,03,00,00,00,05,00,00,00, then 4 reads, then `rsp_data`=0x000000000000000F, `rsp_err`=0.
- SINCOS: A=0x12345678, with the model returning 0x0123456789ABCDEF. Required: 5 writes, 8 reads, `rsp_data`=0x0123456789ABCDEF.
- CLEAR (0x22): exactly 1 write strobe (data 0x22), 0 read strobes, `rsp_valid` with `rsp_data`=0 and `rsp_err`=0.
- Command 0x55: zero strobes; `rsp_err`=1 is valid within 2 cycles of acceptance.
- BUSY held at 1 forever with TIMEOUT_CYCLES=64:
  - With `HERALD_HOST_TIMEOUT_EN`: `rsp_err`=1 after 64 poll cycles.
  - Without it: no response after 1000 cycles.
- `rst_n` low for 1 cycle during the 3rd write byte: all bus outputs are 0 on the next cycle. A following MUL of 2×7 then returns 14.
- `rsp_ready` held low for 10 cycles: `rsp_valid`/`rsp_data` remain stable and `req_ready` stays 0 until the handshake completes.
